// File: rtl/dram_calib_gate_pkg.sv
// Shared types for the DRAM calibration gate: FSM states, counter width and default AXI bus structs.
package dram_calib_gate_pkg;

  localparam int unsigned CntWidth  = 8;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DRAINED  = 2'd3
  } gate_state_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
  } calib_axi_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } calib_axi_w_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } calib_axi_b_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } calib_axi_r_t;

  typedef struct packed {
    calib_axi_ax_t aw;
    logic          aw_valid;
    calib_axi_w_t  w;
    logic          w_valid;
    logic          b_ready;
    calib_axi_ax_t ar;
    logic          ar_valid;
    logic          r_ready;
  } calib_axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    calib_axi_b_t b;
    logic         r_valid;
    calib_axi_r_t r;
  } calib_axi_resp_t;

endpackage

// File: rtl/dram_txn_counter.sv
// Outstanding-transaction counter: never wraps, reports full against a programmable limit.
module dram_txn_counter
  import dram_calib_gate_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] count_q;

  // Simultaneous inc/dec cancel; both ends saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && !dec_i && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q >= max_i);
  assign empty_o = (count_q == '0);

  underflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && (count_q == '0)));

endmodule

// File: rtl/dram_calib_gate.sv
// Gates AXI traffic to the DRAM controller until calibration completes and quiesces it on request.
module dram_calib_gate
  import dram_calib_gate_pkg::*;
#(
  parameter type         axi_req_t  = calib_axi_req_t,
  parameter type         axi_resp_t = calib_axi_resp_t,
  parameter int unsigned MaxTxns    = 8,
  parameter int unsigned CalTimeout = 2**20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                calib_done_i,
  input  logic                drain_req_i,
  input  axi_req_t            slv_req_i,
  output axi_resp_t           slv_rsp_o,
  output axi_req_t            mst_req_o,
  input  axi_resp_t           mst_rsp_i,
  output logic                drained_o,
  output logic                active_o,
  output logic                cal_timeout_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic [CntWidth-1:0] rd_outstanding_o
);

  localparam int unsigned TmoWidth = $clog2(CalTimeout + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxns);

  gate_state_e state_q, state_d;
  logic aw_ok, ar_ok, w_ok;
  logic aw_hs, ar_hs, b_hs, r_last_hs;
  logic wr_full, wr_empty, rd_full, rd_empty;
  logic [TmoWidth-1:0] tmo_q;
  logic cal_timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_WAIT_CAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and gate enables; enables depend only on registered state/counters.
  always_comb begin
    state_d   = state_q;
    aw_ok     = 1'b0;
    ar_ok     = 1'b0;
    w_ok      = 1'b0;
    active_o  = 1'b0;
    drained_o = 1'b0;
    unique case (state_q)
      ST_WAIT_CAL: begin
        if (calib_done_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        active_o = 1'b1;
        aw_ok    = !wr_full;
        ar_ok    = !rd_full;
        w_ok     = 1'b1;
        if (drain_req_i || !calib_done_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_ok = 1'b1;
        if (wr_empty && rd_empty && !aw_hs && !ar_hs) state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        drained_o = 1'b1;
        if (!calib_done_i) begin
          state_d = ST_WAIT_CAL;
        end else if (!drain_req_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_WAIT_CAL;
    endcase
  end

  // Payloads and response channels pass straight through; only handshakes are gated.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_ok;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_ok;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_ok;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_ok;
  end

  assign aw_hs     = slv_req_i.aw_valid & mst_rsp_i.aw_ready & aw_ok;
  assign ar_hs     = slv_req_i.ar_valid & mst_rsp_i.ar_ready & ar_ok;
  assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

  dram_txn_counter #(.Width(CntWidth)) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .max_i   (MaxCnt),
    .count_o (wr_outstanding_o),
    .full_o  (wr_full),
    .empty_o (wr_empty)
  );

  dram_txn_counter #(.Width(CntWidth)) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (ar_hs),
    .dec_i   (r_last_hs),
    .max_i   (MaxCnt),
    .count_o (rd_outstanding_o),
    .full_o  (rd_full),
    .empty_o (rd_empty)
  );

  // Calibration watchdog: flag is sticky until reset, the FSM keeps waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q         <= '0;
      cal_timeout_q <= 1'b0;
    end else begin
      if (state_q != ST_WAIT_CAL) begin
        tmo_q <= '0;
      end else if (tmo_q != TmoWidth'(CalTimeout)) begin
        tmo_q <= tmo_q + TmoWidth'(1);
      end
      if ((state_q == ST_WAIT_CAL) && (tmo_q == TmoWidth'(CalTimeout - 1))) begin
        cal_timeout_q <= 1'b1;
      end
    end
  end

  assign cal_timeout_o = cal_timeout_q;

endmodule
